// File: rtl/mac_normalize_pkg.sv
// Shared MAC subsystem constants, used by the align, accumulate and normalize stages.
package mac_pkg;

    localparam int SUM_W   = 18;
    localparam int EXP_W   = 6;
    localparam int MANT_W  = 4;
    localparam int REF_BIT = 13;
    localparam int QF_W    = 5;

    // Width of a bit index into the accumulated sum.
    localparam int POS_W   = $clog2(SUM_W);

    // Signed exponent width; two extra bits cover both underflow and overflow headroom.
    localparam int ES_W    = EXP_W + 2;

endpackage

// File: rtl/mac_normalize_if.sv
// Data bus of the normalize stage: aligned sum in, sign/exponent/mantissa out.
interface mac_normalize_if;
    import mac_pkg::*;

    logic               i_valid;
    logic [SUM_W-1:0]   i_sum;
    logic [EXP_W-1:0]   i_max_exp;
    logic [QF_W-1:0]    i_Q_frac;

    logic               o_valid;
    logic               o_sign;
    logic [EXP_W-1:0]   o_exp;
    logic [MANT_W-1:0]  o_mant;
    logic               o_zero;
    logic [QF_W-1:0]    o_Q_frac;

    modport master (
        output i_valid, i_sum, i_max_exp, i_Q_frac,
        input  o_valid, o_sign, o_exp, o_mant, o_zero, o_Q_frac
    );

    modport slave (
        input  i_valid, i_sum, i_max_exp, i_Q_frac,
        output o_valid, o_sign, o_exp, o_mant, o_zero, o_Q_frac
    );

endinterface

// File: rtl/mac_lead_one_det.sv
// Combinational leading-one detector over the SUM_W-bit magnitude.
module mac_lead_one_det
    import mac_pkg::*;
(
    input  logic [SUM_W-1:0] mag,
    output logic [POS_W-1:0] pos,
    output logic             found
);

    // Scan upward so the highest set bit is the last to win.
    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < SUM_W; i++) begin
            if (mag[i]) begin
                pos   = POS_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_normalize.sv
// Final MAC stage: two's-complement aligned sum plus shared exponent back to
// normalized sign/exponent/mantissa. Two register stages, no backpressure.
// Build option: define MAC_NORM_ROUND_EN for round-to-nearest-even,
// otherwise the mantissa is truncated and no rounding adder exists.
module mac_normalize
    import mac_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    mac_normalize_if.slave  bus
);

    logic [SUM_W-1:0]         in_mag;

    logic                     s1_valid;
    logic                     s1_sign;
    logic [SUM_W-1:0]         s1_mag;
    logic [EXP_W-1:0]         s1_max_exp;
    logic [QF_W-1:0]          s1_q_frac;

    logic [POS_W-1:0]         lead_pos;
    logic                     lead_found;
    logic [POS_W-1:0]         shift_amt;
    logic [MANT_W-1:0]        mant_t;
    logic [MANT_W-1:0]        mant_r;
    logic signed [ES_W-1:0]   e_raw;
    logic signed [ES_W-1:0]   e_fin;
    logic                     underflow;
    logic                     overflow;

    logic                     res_sign;
    logic [EXP_W-1:0]         res_exp;
    logic [MANT_W-1:0]        res_mant;
    logic                     res_zero;

    logic                     out_valid;
    logic                     out_sign;
    logic [EXP_W-1:0]         out_exp;
    logic [MANT_W-1:0]        out_mant;
    logic                     out_zero;
    logic [QF_W-1:0]          out_q_frac;

    // Magnitude of the incoming sum; the most negative value maps to 2^(SUM_W-1) without overflow.
    always_comb begin
        in_mag = bus.i_sum[SUM_W-1] ? (~bus.i_sum + SUM_W'(1)) : bus.i_sum;
    end

    // Stage 1: split into sign and magnitude and carry exponent/tags alongside.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_mag     <= '0;
            s1_max_exp <= '0;
            s1_q_frac  <= '0;
        end else begin
            s1_valid   <= bus.i_valid;
            s1_sign    <= bus.i_sum[SUM_W-1];
            s1_mag     <= in_mag;
            s1_max_exp <= bus.i_max_exp;
            s1_q_frac  <= bus.i_Q_frac;
        end
    end

    mac_lead_one_det u_lod (
        .mag   (s1_mag),
        .pos   (lead_pos),
        .found (lead_found)
    );

`ifdef MAC_NORM_ROUND_EN
    logic [SUM_W-1:0]  norm;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MANT_W:0]   mant_sum;
    logic              carry;

    // Normalize, then round to nearest even; a carry-out renormalizes to 1.000 and bumps the exponent.
    always_comb begin
        shift_amt = POS_W'(SUM_W - 1) - lead_pos;
        norm      = s1_mag << shift_amt;
        mant_t    = norm[SUM_W-1 -: MANT_W];
        guard     = norm[SUM_W-1-MANT_W];
        sticky    = |norm[SUM_W-2-MANT_W:0];
        round_up  = guard & (sticky | mant_t[0]);
        mant_sum  = {1'b0, mant_t} + (MANT_W+1)'(round_up);
        carry     = mant_sum[MANT_W];
        mant_r    = carry ? {1'b1, {(MANT_W-1){1'b0}}} : mant_sum[MANT_W-1:0];
        e_raw     = ES_W'(s1_max_exp) + ES_W'(lead_pos) - ES_W'(REF_BIT);
        e_fin     = e_raw + ES_W'(carry);
    end
`else
    // Normalize and keep only the top MANT_W bits; everything below is dropped.
    always_comb begin
        shift_amt = POS_W'(SUM_W - 1) - lead_pos;
        mant_t    = MANT_W'(SUM_W'(s1_mag << shift_amt) >> (SUM_W - MANT_W));
        mant_r    = mant_t;
        e_raw     = ES_W'(s1_max_exp) + ES_W'(lead_pos) - ES_W'(REF_BIT);
        e_fin     = e_raw;
    end
`endif

    // Exception muxing on the final exponent: true zero, underflow flush, saturation on overflow.
    always_comb begin
        underflow = e_fin[ES_W-1];
        overflow  = !e_fin[ES_W-1] && (e_fin[ES_W-2:EXP_W] != '0);
        res_sign  = s1_sign;
        res_exp   = e_fin[EXP_W-1:0];
        res_mant  = mant_r;
        res_zero  = 1'b0;
        if (!lead_found) begin
            res_sign = 1'b0;
            res_exp  = '0;
            res_mant = '0;
            res_zero = 1'b1;
        end else if (underflow) begin
            res_exp  = '0;
            res_mant = '0;
            res_zero = 1'b1;
        end else if (overflow) begin
            res_exp  = '1;
            res_mant = '1;
        end
    end

    // Stage 2: register the normalized result and tags into the outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid  <= 1'b0;
            out_sign   <= 1'b0;
            out_exp    <= '0;
            out_mant   <= '0;
            out_zero   <= 1'b0;
            out_q_frac <= '0;
        end else begin
            out_valid  <= s1_valid;
            out_sign   <= res_sign;
            out_exp    <= res_exp;
            out_mant   <= res_mant;
            out_zero   <= res_zero;
            out_q_frac <= s1_q_frac;
        end
    end

    assign bus.o_valid  = out_valid;
    assign bus.o_sign   = out_sign;
    assign bus.o_exp    = out_exp;
    assign bus.o_mant   = out_mant;
    assign bus.o_zero   = out_zero;
    assign bus.o_Q_frac = out_q_frac;

endmodule

// File: tb/tb_mac_normalize.sv
// Self-checking bench for mac_normalize. Expected results come from an
// integer-arithmetic model of the number format; it follows MAC_NORM_ROUND_EN
// so the same bench serves both builds.
module tb_mac_normalize;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    mac_normalize_if bus ();

    mac_normalize dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected packed result {valid, sign, exp[5:0], mant[3:0], zero, qf[4:0]}; front = what the outputs show now.
    logic [17:0] exp_q[$];

    function automatic logic [17:0] ref_result(input logic [17:0] sum, input logic [5:0] me,
                                               input logic [4:0] qf);
        int   v, m, p, e, mant, rem, half;
        logic s;
        v = sum[17] ? (int'(sum) - (1 << 18)) : int'(sum);
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return {1'b1, 1'b0, 6'd0, 4'd0, 1'b1, qf};
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        e = int'(me) + p - 13;
        if (p >= 3) begin
            mant = m >> (p - 3);
            rem  = m - (mant << (p - 3));
        end else begin
            mant = m << (3 - p);
            rem  = 0;
        end
`ifdef MAC_NORM_ROUND_EN
        if (p >= 4) begin
            half = 1 << (p - 4);
            if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
        end
        if (mant == 16) begin
            mant = 8;
            e++;
        end
`else
        half = rem;
`endif
        if (e < 0)  return {1'b1, s, 6'd0, 4'd0, 1'b1, qf};
        if (e > 63) return {1'b1, s, 6'h3F, 4'hF, 1'b0, qf};
        return {1'b1, s, e[5:0], mant[3:0], 1'b0, qf};
    endfunction

    // Present one input sample, record what it should produce, and advance one clock.
    task automatic drive(input logic v, input logic [17:0] s, input logic [5:0] me,
                         input logic [4:0] qf, input logic [17:0] expected);
        bus.i_valid   = v;
        bus.i_sum     = s;
        bus.i_max_exp = me;
        bus.i_Q_frac  = qf;
        exp_q.push_back(v ? expected : 18'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        bus.i_valid   = 1'b0;
        bus.i_sum     = '0;
        bus.i_max_exp = '0;
        bus.i_Q_frac  = '0;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        obs = {bus.o_valid, bus.o_sign, bus.o_exp, bus.o_mant, bus.o_zero, bus.o_Q_frac};
        tests_run++;
        if (obs !== 18'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 18'd0);
        end
        i_rst = 1'b0;
        exp_q = {18'd0};
    endtask

    task automatic test_directed();
        logic [17:0] sums[10];
        logic [5:0]  mes[10];
        logic [17:0] want[10];
        logic [17:0] obs, expd;
        sums[0] = 18'h02000; mes[0] = 6'd20; want[0] = {1'b1, 1'b0, 6'd20, 4'b1000, 1'b0, 5'd0};
        sums[1] = 18'h3E000; mes[1] = 6'd20; want[1] = {1'b1, 1'b1, 6'd20, 4'b1000, 1'b0, 5'd1};
`ifdef MAC_NORM_ROUND_EN
        sums[2] = 18'h03E00; mes[2] = 6'd20; want[2] = {1'b1, 1'b0, 6'd21, 4'b1000, 1'b0, 5'd2};
        sums[3] = 18'h02300; mes[3] = 6'd20; want[3] = {1'b1, 1'b0, 6'd20, 4'b1001, 1'b0, 5'd3};
`else
        sums[2] = 18'h03E00; mes[2] = 6'd20; want[2] = {1'b1, 1'b0, 6'd20, 4'b1111, 1'b0, 5'd2};
        sums[3] = 18'h02300; mes[3] = 6'd20; want[3] = {1'b1, 1'b0, 6'd20, 4'b1000, 1'b0, 5'd3};
`endif
        sums[4] = 18'h02200; mes[4] = 6'd20; want[4] = {1'b1, 1'b0, 6'd20, 4'b1000, 1'b0, 5'd4};
        sums[5] = 18'h00000; mes[5] = 6'd20; want[5] = {1'b1, 1'b0, 6'd0,  4'b0000, 1'b1, 5'd5};
        sums[6] = 18'h00001; mes[6] = 6'd5;  want[6] = {1'b1, 1'b0, 6'd0,  4'b0000, 1'b1, 5'd6};
        sums[7] = 18'h10000; mes[7] = 6'd62; want[7] = {1'b1, 1'b0, 6'd63, 4'b1111, 1'b0, 5'd7};
        sums[8] = 18'h20000; mes[8] = 6'd0;  want[8] = {1'b1, 1'b1, 6'd4,  4'b1000, 1'b0, 5'd8};
        sums[9] = 18'h3FFFF; mes[9] = 6'd0;  want[9] = {1'b1, 1'b1, 6'd0,  4'b0000, 1'b1, 5'd9};
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drive(1'b1, sums[i], mes[i], 5'(i), want[i]);
            else        drive(1'b0, 18'd0, 6'd0, 5'd0, 18'd0);
            expd = exp_q.pop_front();
            obs  = {bus.o_valid, bus.o_sign, bus.o_exp, bus.o_mant, bus.o_zero, bus.o_Q_frac};
            tests_run++;
            if (expd[17] ? (obs !== expd) : (bus.o_valid !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL directed_cycle%0d: got %h expected %h", i, obs, expd);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] s, obs, expd;
        logic [5:0]  me;
        logic [4:0]  qf;
        logic        v;
        for (int i = 0; i < 60; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            s  = 18'($urandom) >> $urandom_range(0, 17);
            if ($urandom_range(0, 1) == 1) s = -s;
            me = 6'($urandom_range(0, 63));
            qf = 5'($urandom);
            drive(v, s, me, qf, ref_result(s, me, qf));
            expd = exp_q.pop_front();
            obs  = {bus.o_valid, bus.o_sign, bus.o_exp, bus.o_mant, bus.o_zero, bus.o_Q_frac};
            tests_run++;
            if (expd[17] ? (obs !== expd) : (bus.o_valid !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, obs, expd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] s, obs, expd;
        logic [5:0]  me;
        for (int i = 0; i < 10; i++) begin
            s  = 18'($urandom);
            me = 6'($urandom_range(10, 50));
            if (i < 8) drive(1'b1, s, me, 5'(i), ref_result(s, me, 5'(i)));
            else       drive(1'b0, 18'd0, 6'd0, 5'd0, 18'd0);
            expd = exp_q.pop_front();
            obs  = {bus.o_valid, bus.o_sign, bus.o_exp, bus.o_mant, bus.o_zero, bus.o_Q_frac};
            tests_run++;
            if (expd[17] ? (obs !== expd) : (bus.o_valid !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back_cycle%0d: got %h expected %h", i, obs, expd);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [17:0] s, obs, expd;
        logic [5:0]  me;
        for (int i = 0; i < 4; i++) begin
            s  = 18'($urandom);
            me = 6'($urandom_range(10, 50));
            drive(1'b1, s, me, 5'(i), ref_result(s, me, 5'(i)));
            expd = exp_q.pop_front();
            obs  = {bus.o_valid, bus.o_sign, bus.o_exp, bus.o_mant, bus.o_zero, bus.o_Q_frac};
            tests_run++;
            if (expd[17] ? (obs !== expd) : (bus.o_valid !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL midstream_cycle%0d: got %h expected %h", i, obs, expd);
            end
        end
        bus.i_valid = 1'b1;
        bus.i_sum   = 18'h02000;
        i_rst = 1'b1;
        #1;
        obs = {bus.o_valid, bus.o_sign, bus.o_exp, bus.o_mant, bus.o_zero, bus.o_Q_frac};
        tests_run++;
        if (obs !== 18'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_clear: got %h expected %h", obs, 18'd0);
        end
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        i_rst = 1'b0;
        exp_q = {18'd0};
        for (int i = 0; i < 5; i++) begin
            s  = 18'h3E000;
            me = 6'd20;
            if (i == 2) drive(1'b1, s, me, 5'd17, {1'b1, 1'b1, 6'd20, 4'b1000, 1'b0, 5'd17});
            else        drive(1'b0, s, me, 5'd0, 18'd0);
            expd = exp_q.pop_front();
            obs  = {bus.o_valid, bus.o_sign, bus.o_exp, bus.o_mant, bus.o_zero, bus.o_Q_frac};
            tests_run++;
            if (expd[17] ? (obs !== expd) : (bus.o_valid !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL post_reset_cycle%0d: got %h expected %h", i, obs, expd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/mac_normalize.md
Name: mac_normalize

Overview:
- Final stage of the MAC subsystem; counterpart of the alignment stage.
- Alignment converts sign-magnitude partial products into two's-complement fixed point referenced to max_exp; this block goes the other way.
- Takes the accumulated two's-complement sum of aligned partial products plus the shared max exponent, and emits a normalized sign/exponent/mantissa result.
- 2-stage pipeline, one result per cycle, no backpressure; valid and Q_frac tags travel alongside the data.

Parameters:
- SUM_W, 18, width of accumulated two's-complement sum (aligned 15-bit pp plus 3 growth bits).
- EXP_W, 6, exponent width (unsigned).
- MANT_W, 4, output mantissa width including explicit leading one.
- REF_BIT, 13, sum bit position whose weight equals 2^max_exp.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input sample valid.
- i_sum  in  SUM_W  accumulated aligned sum, two's complement; bit k weight 2^(max_exp+k-REF_BIT).
- i_max_exp  in  EXP_W  shared exponent the sum was aligned to.
- i_Q_frac  in  5  tag, passed through.
- o_valid  out  1  output valid.
- o_sign  out  1  result sign.
- o_exp  out  EXP_W  result exponent.
- o_mant  out  MANT_W  normalized mantissa, MSB = leading one (0 when o_zero).
- o_zero  out  1  result is zero (true zero, or underflow flush).
- o_Q_frac  out  5  delayed i_Q_frac.

Behaviour:
- Reset: all pipeline registers and all outputs 0. Assertion mid-stream discards in-flight samples; first o_valid comes 2 cycles after the first post-reset i_valid.
- Latency: i_valid at edge t produces o_valid at edge t+2. Fully pipelined; back-to-back valids produce back-to-back outputs.
- Data/tag registers load every cycle regardless of i_valid. Outputs are meaningful only when o_valid=1.
- Stage 1 (registered):
  - sign = i_sum[SUM_W-1].
  - mag = sign ? -i_sum : i_sum, SUM_W bits unsigned. 18'h20000 gives mag 2^17; no overflow.
  - Also registers max_exp, valid and Q_frac.
- Stage 2 (combinational, registered into outputs):
  - p = index of leading one of mag, range 0..SUM_W-1.
  - Left-normalize mag so bit p lands at the MSB.
  - mant = bits p..p-MANT_W+1 (zero-filled below bit 0).
  - guard = bit p-MANT_W; sticky = OR of all lower bits.
  - e = max_exp + p - REF_BIT, computed signed with width EXP_W+2.
- Rounding: round-to-nearest-even. Increment when guard & (sticky | mant[0]).
  - Rounding carry-out: mant = 1000, e = e+1.
- Zero: mag == 0 → o_zero=1, o_sign=0, o_exp=0, o_mant=0.
- Underflow: e < 0 → flush. o_zero=1, o_exp=0, o_mant=0; o_sign keeps the input sign.
- Overflow: e > 2^EXP_W-1, evaluated after rounding → o_exp = all ones, o_mant = all ones, o_zero=0.

Optional Feature:
- Macro: MAC_NORM_ROUND_EN.
- Defined: round-to-nearest-even as above.
- Undefined: truncation. Guard and sticky are ignored and there is no rounding carry; the adder is absent from the netlist. Zero/underflow/overflow rules unchanged.

Decomposition:
- Package mac_pkg holds SUM_W, EXP_W, MANT_W, REF_BIT and the Q_frac width (5), shared with the align and accumulate stages.
- One sub-module, mac_lead_one_det: combinational SUM_W-bit leading-one detector. Outputs position p (5 bits) and a valid bit (mag != 0).
- Shifter, rounding and exception muxing stay in mac_normalize.

Test Plan:
- Basic: i_sum=18'h02000, i_max_exp=20, i_valid=1 → two cycles later o_valid=1, sign 0, exp 20, mant 4'b1000, zero 0.
- Negative: i_sum=18'h3E000 (−0x2000), i_max_exp=20 → sign 1, exp 20, mant 4'b1000.
- Rounding tie to even with carry: i_sum=18'h03E00, i_max_exp=20 → with ROUND_EN mant 4'b1000, exp 21; without ROUND_EN mant 4'b1111, exp 20.
- Exceptions:
  - i_sum=0 → o_zero=1, sign/exp/mant 0.
  - i_sum=18'h00001, i_max_exp=5 → flush, o_zero=1.
  - i_sum=18'h10000, i_max_exp=62 → exp 63, mant 4'b1111.
  - i_sum=18'h20000, i_max_exp=0 → sign 1, exp 4, mant 1000.
- Streaming and reset: 8 consecutive valids with distinct i_Q_frac 0..7 → 8 consecutive o_valid, o_Q_frac in order, each result matches a reference model. Assert i_rst on cycle 4 → outputs 0 immediately (asynchronous); no stale o_valid after release.
